// File: rtl/piece_bag_pkg.sv
// Shared types and constants for the 7-bag tetromino generator.
package piece_bag_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;

  localparam logic [6:0] BAG_FULL  = 7'h7F;
  localparam int         PIECE_NUM = 7;

  // Number of undrawn pieces left in a bag mask.
  function automatic logic [2:0] bag_popcount(input logic [6:0] mask);
    logic [2:0] c;
    c = 3'd0;
    for (int b = 0; b < PIECE_NUM; b++) c = c + {2'd0, mask[b]};
    return c;
  endfunction

endpackage

// File: rtl/piece_bag_bag_select.sv
// Combinational draw step: picks the k-th undrawn piece, k = rand mod cnt,
// and produces the bag mask/count that follow the draw.
module bag_select
  import piece_bag_pkg::*;
(
  input  logic [6:0] mask_i,
  input  logic [7:0] rand_i,
  output logic [2:0] piece_o,
  output logic [6:0] mask_o,
  output logic [2:0] cnt_o
);

  logic [2:0] cnt;
  logic [2:0] k;
  piece_e     pick;
  logic [6:0] cleared;

  assign cnt = bag_popcount(mask_i);

  // Reduce the random byte modulo the live count (1..7) with constant divisors.
  always_comb begin
    k = 3'd0;
    case (cnt)
      3'd2:    k = 3'(rand_i % 8'd2);
      3'd3:    k = 3'(rand_i % 8'd3);
      3'd4:    k = 3'(rand_i % 8'd4);
      3'd5:    k = 3'(rand_i % 8'd5);
      3'd6:    k = 3'(rand_i % 8'd6);
      3'd7:    k = 3'(rand_i % 8'd7);
      default: k = 3'd0;
    endcase
  end

  // Walk the mask from bit 0 up and take the k-th set bit.
  always_comb begin
    logic [2:0] seen;
    logic       found;
    pick  = PIECE_I;
    seen  = 3'd0;
    found = 1'b0;
    for (int b = 0; b < PIECE_NUM; b++) begin
      if (mask_i[b]) begin
        if (!found && seen == k) begin
          pick  = piece_e'(3'(b));
          found = 1'b1;
        end
        seen = seen + 3'd1;
      end
    end
  end

  // Clear the drawn bit; an emptied bag reloads at the same edge.
  always_comb begin
    cleared = mask_i & ~(7'd1 << pick);
    if (cleared == 7'd0) begin
      mask_o = BAG_FULL;
      cnt_o  = 3'd7;
    end else begin
      mask_o = cleared;
      cnt_o  = cnt - 3'd1;
    end
  end

  assign piece_o = pick;

endmodule

// File: rtl/piece_bag_generator.sv
// 7-bag piece generator with a shift-register preview queue and a
// valid/yumi pop interface. All outputs come straight from registers.
module piece_bag_generator
  import piece_bag_pkg::*;
#(
  parameter int width_p       = 32,
  parameter int queue_depth_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [width_p-1:0]             random_i,
  output logic                           piece_v_o,
  output logic [2:0]                     piece_o,
  input  logic                           yumi_i,
  output logic [queue_depth_p-1:0][2:0]  preview_o,
  output logic [queue_depth_p-1:0]       preview_v_o,
  output logic [2:0]                     bag_remaining_o
);

  localparam int OW = $clog2(queue_depth_p + 1);

  logic [6:0]                    mask_r, mask_n;
  logic [2:0]                    cnt_r, cnt_n;
  logic [OW-1:0]                 occ_r, occ_n, wpos;
  logic [queue_depth_p-1:0][2:0] q_r, q_n;
  logic [queue_depth_p-1:0]      v_r, v_n;
  logic [2:0]                    sel_piece;
  logic                          pop, draw;

  // Only the low byte of the random word matters.
  generate
    if (width_p > 8) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^random_i[width_p-1:8];
    end
  endgenerate

  // A pop while empty is ignored; a pop always frees room for a draw.
  assign pop  = yumi_i & v_r[0];
  assign draw = (int'(occ_r) < queue_depth_p) | pop;
  assign wpos = occ_r - OW'(pop);

  bag_select u_sel (
    .mask_i  (mask_r),
    .rand_i  (random_i[7:0]),
    .piece_o (sel_piece),
    .mask_o  (mask_n),
    .cnt_o   (cnt_n)
  );

  // Per-entry next state: shift down on pop, then land the new draw at wpos.
  generate
    for (genvar i = 0; i < queue_depth_p; i++) begin : g_ent
      localparam logic [OW-1:0] IDX = OW'(i);
      always_comb begin
        q_n[i] = q_r[i];
        v_n[i] = v_r[i];
        if (pop) begin
          if (i == queue_depth_p - 1) begin
            q_n[i] = 3'd0;
            v_n[i] = 1'b0;
          end else begin
            q_n[i] = q_r[(i+1) % queue_depth_p];
            v_n[i] = v_r[(i+1) % queue_depth_p];
          end
        end
        if (draw && wpos == IDX) begin
          q_n[i] = sel_piece;
          v_n[i] = 1'b1;
        end
      end
    end
  endgenerate

  // Occupancy moves by draw minus pop.
  always_comb begin
    occ_n = occ_r;
    if (draw && !pop)      occ_n = occ_r + OW'(1);
    else if (!draw && pop) occ_n = occ_r - OW'(1);
  end

  // State registers; reset drops the queue and refills the bag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mask_r <= BAG_FULL;
      cnt_r  <= 3'd7;
      occ_r  <= '0;
      q_r    <= '0;
      v_r    <= '0;
    end else begin
      occ_r <= occ_n;
      q_r   <= q_n;
      v_r   <= v_n;
      if (draw) begin
        mask_r <= mask_n;
        cnt_r  <= cnt_n;
      end
    end
  end

  assign piece_v_o       = v_r[0];
  assign piece_o         = q_r[0];
  assign preview_o       = q_r;
  assign preview_v_o     = v_r;
  assign bag_remaining_o = cnt_r;

endmodule

// File: tb/tb_piece_bag_generator.sv
// Bench for piece_bag_generator: directed tables, hand sequences and a
// randomized run against a list-based bag/queue model.
module tb_piece_bag_generator;

  localparam int D = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [31:0]       random_i;
  logic              piece_v_o;
  logic [2:0]        piece_o;
  logic              yumi_i;
  logic [D-1:0][2:0] preview_o;
  logic [D-1:0]      preview_v_o;
  logic [2:0]        bag_remaining_o;

  int checks = 0;
  int errors = 0;

  piece_bag_generator #(.width_p(32), .queue_depth_p(D)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .random_i        (random_i),
    .piece_v_o       (piece_v_o),
    .piece_o         (piece_o),
    .yumi_i          (yumi_i),
    .preview_o       (preview_o),
    .preview_v_o     (preview_v_o),
    .bag_remaining_o (bag_remaining_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit y;
    int v;
    int piece;
    int rem;
    int pv;
  } vec_t;

  // Model: queue of pending pieces and sorted list of undrawn pieces.
  int mq[$];
  int mbag[$];

  function automatic void model_reset();
    mq.delete();
    mbag.delete();
    for (int p = 0; p < 7; p++) mbag.push_back(p);
  endfunction

  function automatic void model_step(input int rnd, input bit y);
    bit pop, drw;
    int k, p;
    pop = y && (mq.size() > 0);
    drw = (mq.size() < D) || pop;
    if (pop) void'(mq.pop_front());
    if (drw) begin
      k = (rnd & 255) % mbag.size();
      p = mbag[k];
      mbag.delete(k);
      if (mbag.size() == 0) for (int q = 0; q < 7; q++) mbag.push_back(q);
      mq.push_back(p);
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input int rnd, input bit y);
    reset_i  = r;
    random_i = rnd;
    yumi_i   = y;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_model(input int n);
    bit ok;
    int ev, epv;
    ok  = 1'b1;
    ev  = (mq.size() > 0);
    epv = 0;
    for (int i = 0; i < mq.size(); i++) begin
      epv |= (1 << i);
      if (int'(preview_o[i]) != mq[i]) ok = 1'b0;
    end
    if (int'(piece_v_o) != ev) ok = 1'b0;
    if (int'(preview_v_o) != epv) ok = 1'b0;
    if (int'(bag_remaining_o) != mbag.size()) ok = 1'b0;
    if (mq.size() > D) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model cycle %0d: got v=%0d pv=%h prev=%h rem=%0d expected v=%0d pv=%h rem=%0d occ=%0d",
               n, piece_v_o, preview_v_o, preview_o, bag_remaining_o, ev, epv, mbag.size(), mq.size());
    end
  endtask

  vec_t vecs[13];
  int   stream[$];
  int   pops, ncyc, rnd, gm;
  bit   y;

  initial begin
    reset_i = 1'b1; random_i = 0; yumi_i = 1'b0;

    vecs[0]  = '{0, 1, 0, 6, 4'h1};
    vecs[1]  = '{0, 1, 0, 5, 4'h3};
    vecs[2]  = '{0, 1, 0, 4, 4'h7};
    vecs[3]  = '{0, 1, 0, 3, 4'hF};
    vecs[4]  = '{0, 1, 0, 3, 4'hF};
    vecs[5]  = '{1, 1, 1, 2, 4'hF};
    vecs[6]  = '{1, 1, 2, 1, 4'hF};
    vecs[7]  = '{1, 1, 3, 7, 4'hF};
    vecs[8]  = '{1, 1, 4, 6, 4'hF};
    vecs[9]  = '{1, 1, 5, 5, 4'hF};
    vecs[10] = '{1, 1, 6, 4, 4'hF};
    vecs[11] = '{1, 1, 0, 3, 4'hF};
    vecs[12] = '{1, 1, 1, 2, 4'hF};

    // Reset state
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rst_v", piece_v_o, 0);
    chk("rst_piece", piece_o, 0);
    chk("rst_prev", int'(preview_o), 0);
    chk("rst_pv", preview_v_o, 0);
    chk("rst_rem", bag_remaining_o, 7);

    // random_i=0: fill then stream
    for (int i = 0; i < 13; i++) begin
      cyc(0, 0, vecs[i].y);
      chk($sformatf("tab%0d_v", i), piece_v_o, vecs[i].v);
      chk($sformatf("tab%0d_piece", i), piece_o, vecs[i].piece);
      chk($sformatf("tab%0d_rem", i), bag_remaining_o, vecs[i].rem);
      chk($sformatf("tab%0d_pv", i), preview_v_o, vecs[i].pv);
      if (i == 3) chk("tab_prev_0123", int'(preview_o), 12'h688);
    end

    // random byte 255: S, Z, I, L
    cyc(1, 0, 0);
    cyc(0, 255, 0);
    chk("r255_first", piece_o, 3);
    cyc(0, 255, 0);
    cyc(0, 255, 0);
    cyc(0, 255, 0);
    chk("r255_prev", int'(preview_o), 12'hC23);
    chk("r255_rem", bag_remaining_o, 3);

    // Reset mid-stream with full queue and partial bag
    cyc(1, 255, 0);
    chk("mid_rst_v", piece_v_o, 0);
    chk("mid_rst_rem", bag_remaining_o, 7);
    chk("mid_rst_pv", preview_v_o, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    chk("mid_refill_prev", int'(preview_o), 12'h688);
    chk("mid_refill_rem", bag_remaining_o, 3);

    // Stray yumi while empty
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    chk("stray_v", piece_v_o, 1);
    chk("stray_piece", piece_o, 0);
    chk("stray_rem", bag_remaining_o, 6);
    chk("stray_pv", preview_v_o, 4'h1);
    cyc(0, 0, 0);
    chk("stray_pv2", preview_v_o, 4'h3);

    // Randomized run against the model
    cyc(1, 0, 0);
    model_reset();
    check_model(-1);
    pops = 0;
    ncyc = 0;
    while (pops < 7000 && ncyc < 40000) begin
      rnd = int'($urandom);
      y   = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (y) begin
        chk("yumi_legal", piece_v_o, 1);
        stream.push_back(int'(piece_o));
        pops++;
      end
      model_step(rnd, y);
      cyc(0, rnd, y);
      check_model(ncyc);
      ncyc++;
    end
    chk("pop_budget", pops, 7000);
    for (int g = 0; g + 7 <= stream.size(); g += 7) begin
      gm = 0;
      for (int j = 0; j < 7; j++) gm |= (1 << stream[g+j]);
      chk($sformatf("bag_perm%0d", g / 7), gm, 8'h7F);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
